manual_drive_ctrl: RTL and testbench

Parametrised manual-driving controller for the car-simulator top level. Debounces the raw cockpit switches and runs a registered four-state drive FSM with power-on/off, stall and gear-crash detection, a latched reverse gear, and a mileage counter. Generates turn-indicator blink outputs and the 8-bit command byte that the UART transmitter forwards to the simulator.

---
 rtl/manual_drive_ctrl_if.sv | 43 ++++
 rtl/manual_drive_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_manual_drive_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/manual_drive_ctrl_if.sv
// manual_drive_ctrl_if
// Bundles the cockpit switches going into the manual-drive controller and
// the status/command outputs coming back out of it.
//   master : the cockpit side (drives raw switches, observes outputs)
//   slave  : the controller side (samples raw switches, drives outputs)
// Raw inputs : power_on_btn, power_off_btn, throttle, clutch, brake,
//              reverse_sw, turn_left, turn_right, place_barrier, destroy_barrier
// Outputs    : state[1:0], cmd[7:0], cmd_valid, reversing,
//              mileage[MILE_W-1:0], left_led, right_led
interface manual_drive_ctrl_if #(
  parameter int MILE_W = 16
);
  logic              power_on_btn;
  logic              power_off_btn;
  logic              throttle;
  logic              clutch;
  logic              brake;
  logic              reverse_sw;
  logic              turn_left;
  logic              turn_right;
  logic              place_barrier;
  logic              destroy_barrier;

  logic [1:0]        state;
  logic [7:0]        cmd;
  logic              cmd_valid;
  logic              reversing;
  logic [MILE_W-1:0] mileage;
  logic              left_led;
  logic              right_led;

  modport master (
    output power_on_btn, power_off_btn, throttle, clutch, brake, reverse_sw,
           turn_left, turn_right, place_barrier, destroy_barrier,
    input  state, cmd, cmd_valid, reversing, mileage, left_led, right_led
  );

  modport slave (
    input  power_on_btn, power_off_btn, throttle, clutch, brake, reverse_sw,
           turn_left, turn_right, place_barrier, destroy_barrier,
    output state, cmd, cmd_valid, reversing, mileage, left_led, right_led
  );
endinterface

// File: rtl/manual_drive_ctrl.sv
// manual_drive_ctrl
// Manual-driving controller for the car simulator. Every raw cockpit switch
// is synchronised and debounced, then drives a four-state drive FSM
// (POWER_OFF / NOT_STARTING / STARTING / MOVING) with stall and gear-crash
// detection, a latched reverse gear, a saturating mileage counter, blinking
// turn indicators and the command byte forwarded to the simulator UART.
// Ports:
//   clk : system clock
//   rst : synchronous reset, active low
//   bus : manual_drive_ctrl_if.slave (raw switches in, status/cmd out)
module manual_drive_ctrl #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int MILE_TICK       = 100_000_000,
  parameter int MILE_W          = 16,
  parameter int BLINK_HALF      = 50_000_000
) (
  input logic                clk,
  input logic                rst,
  manual_drive_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    POWER_OFF    = 2'b00,
    NOT_STARTING = 2'b01,
    STARTING     = 2'b10,
    MOVING       = 2'b11
  } state_t;

  localparam int NIN = 10;
  localparam int B_PON = 0, B_POFF = 1, B_THR = 2, B_CLU = 3, B_BRK = 4;
  localparam int B_REV = 5, B_TL = 6, B_TR = 7, B_PLACE = 8, B_DESTROY = 9;

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = (MILE_TICK > 1) ? $clog2(MILE_TICK) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(MILE_TICK - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [NIN-1:0]    raw_vec;
  logic [NIN-1:0]    sync1_q, sync2_q, deb_q;
  logic [DW-1:0]     db_cnt_q [NIN];

  state_t            state_q, state_d;
  logic              pon_prev_q;
  logic              reversing_q, reversing_d;
  logic [7:0]        cmd_q, cmd_d, cmd_last_q;
  logic              cmd_valid_q;
  logic [PW-1:0]     presc_q, presc_d;
  logic [MILE_W-1:0] mileage_q, mileage_d;
  logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              blink_off_q, blink_off_d;
  logic              left_led_q, left_led_d, right_led_q, right_led_d;

  logic pon_rise, poff, thr, clu, brk, rev;
  logic enter_off, moving_d, left_act, right_act;

  assign raw_vec = {bus.destroy_barrier, bus.place_barrier, bus.turn_right,
                    bus.turn_left, bus.reverse_sw, bus.brake, bus.clutch,
                    bus.throttle, bus.power_off_btn, bus.power_on_btn};

  assign poff = deb_q[B_POFF];
  assign thr  = deb_q[B_THR];
  assign clu  = deb_q[B_CLU];
  assign brk  = deb_q[B_BRK];
  assign rev  = deb_q[B_REV];

  // Power-on only reacts to a fresh press, so a held button cannot restart
  // the car straight after a stall or gear crash.
  assign pon_rise = deb_q[B_PON] & ~pon_prev_q;

  // Input conditioning: two flops against metastability, then a per-input
  // counter that runs while the synchronised value disagrees with the
  // debounced one. Any agreement restarts the count, so only a value held
  // for DEBOUNCE_CYCLES consecutive cycles gets through.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int i = 0; i < NIN; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw_vec;
      sync2_q <= sync1_q;
      for (int i = 0; i < NIN; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          deb_q[i]    <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Drive FSM next state. Power-off always wins in a powered state; within
  // each state the checks run in priority order, so brake beats throttle
  // in MOVING and a gear crash is only considered when nothing else fires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      POWER_OFF: begin
        if (pon_rise && !poff) state_d = NOT_STARTING;
      end
      NOT_STARTING: begin
        if (poff)                    state_d = POWER_OFF;
        else if (thr && !clu)        state_d = POWER_OFF;
        else if (thr && clu && !brk) state_d = STARTING;
      end
      STARTING: begin
        if (poff)              state_d = POWER_OFF;
        else if (brk)          state_d = NOT_STARTING;
        else if (thr && !clu)  state_d = MOVING;
      end
      MOVING: begin
        if (poff)                               state_d = POWER_OFF;
        else if (brk)                           state_d = NOT_STARTING;
        else if (clu || !thr)                   state_d = STARTING;
        else if ((rev != reversing_q) && !clu)  state_d = POWER_OFF;
      end
      default: state_d = POWER_OFF;
    endcase
  end

  assign enter_off = (state_d == POWER_OFF) && (state_q != POWER_OFF);
  assign moving_d  = (state_d == MOVING);

  // Gear latch and command byte. cmd is built from the upcoming state and
  // gear so it lands on the same edge as the state register.
  always_comb begin
    reversing_d = reversing_q;
    if (enter_off)
      reversing_d = 1'b0;
    else if (((state_q == STARTING) || (state_q == MOVING)) && clu)
      reversing_d = rev;

    cmd_d = 8'h80;
    if (state_d != POWER_OFF)
      cmd_d = {2'b10, deb_q[B_DESTROY], deb_q[B_PLACE], deb_q[B_TR],
               deb_q[B_TL], moving_d & reversing_d, moving_d & ~reversing_d};
  end

  // Mileage: the prescaler only runs while MOVING and restarts from zero
  // on every new MOVING stint; mileage sticks at all-ones and is wiped when
  // the car powers off.
  always_comb begin
    presc_d   = '0;
    mileage_d = mileage_q;
    if (state_q == MOVING) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        if (mileage_q != {MILE_W{1'b1}}) mileage_d = mileage_q + MILE_W'(1);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
    if (enter_off) mileage_d = '0;
  end

  // Indicators share one half-period counter so a hazard (both switches on)
  // blinks both lamps in phase. The off-phase flag starts cleared, so the
  // first registered value after activation is ON.
  always_comb begin
    left_act    = deb_q[B_TL] && (state_q != POWER_OFF);
    right_act   = deb_q[B_TR] && (state_q != POWER_OFF);
    blink_cnt_d = '0;
    blink_off_d = 1'b0;
    left_led_d  = left_act & ~blink_off_q;
    right_led_d = right_act & ~blink_off_q;
    if (left_act || right_act) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        blink_off_d = blink_off_q;
      end
    end
  end

  // All controller state. cmd_valid compares cmd with its previous value so
  // the pulse appears one cycle after the cycle in which cmd changed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= POWER_OFF;
      pon_prev_q  <= 1'b0;
      reversing_q <= 1'b0;
      cmd_q       <= 8'h80;
      cmd_last_q  <= 8'h80;
      cmd_valid_q <= 1'b0;
      presc_q     <= '0;
      mileage_q   <= '0;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
      left_led_q  <= 1'b0;
      right_led_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pon_prev_q  <= deb_q[B_PON];
      reversing_q <= reversing_d;
      cmd_q       <= cmd_d;
      cmd_last_q  <= cmd_q;
      cmd_valid_q <= (cmd_q != cmd_last_q);
      presc_q     <= presc_d;
      mileage_q   <= mileage_d;
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
      left_led_q  <= left_led_d;
      right_led_q <= right_led_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.cmd       = cmd_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.reversing = reversing_q;
  assign bus.mileage   = mileage_q;
  assign bus.left_led  = left_led_q;
  assign bus.right_led = right_led_q;

endmodule

// File: tb/tb_manual_drive_ctrl.sv
// tb_manual_drive_ctrl
// Drives manual_drive_ctrl through directed driving scenarios followed by
// randomized switch activity, comparing every output every cycle with a
// behavioural model built from the controller's rules.
module tb_manual_drive_ctrl;

  localparam int D      = 4;
  localparam int MT     = 10;
  localparam int MW     = 4;
  localparam int BH     = 3;
  localparam int MAXMIL = (1 << MW) - 1;
  localparam int HLEN   = D + 3;

  localparam int S_OFF = 0, S_NS = 1, S_ST = 2, S_MV = 3;

  localparam bit [9:0] PON   = 10'b00_0000_0001;
  localparam bit [9:0] POFF  = 10'b00_0000_0010;
  localparam bit [9:0] THR   = 10'b00_0000_0100;
  localparam bit [9:0] CLU   = 10'b00_0000_1000;
  localparam bit [9:0] BRK   = 10'b00_0001_0000;
  localparam bit [9:0] REV   = 10'b00_0010_0000;
  localparam bit [9:0] TURNS = 10'b00_1100_0000;

  logic clk;
  logic rst;
  bit [9:0] stim;

  int total = 0;
  int bad   = 0;

  // model state
  bit [9:0] hist[$];
  bit [9:0] mDeb;
  bit       mPonPrev;
  int       mState;
  bit       mRev;
  bit [7:0] mCmd, mCmdPrev;
  bit       mValid;
  int       mMile, mRun, mBlinkRun;
  bit       mLl, mLr;

  manual_drive_ctrl_if #(.MILE_W(MW)) bus ();

  manual_drive_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .MILE_TICK(MT),
    .MILE_W(MW),
    .BLINK_HALF(BH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    hist.delete();
    for (int i = 0; i < HLEN; i++) hist.push_back('0);
    mDeb = '0; mPonPrev = 0; mState = S_OFF; mRev = 0;
    mCmd = 8'h80; mCmdPrev = 8'h80; mValid = 0;
    mMile = 0; mRun = 0; mBlinkRun = 0; mLl = 0; mLr = 0;
  endtask

  // One clock edge of the reference: a debounced value changes once the
  // last D synchronised samples (raw input two edges back) all agree.
  task automatic modelStep();
    bit [9:0] newDeb;
    bit [7:0] nCmd;
    bit rise, poff, thr, clu, brk, nRev, enterOff, phaseOn, v, same;
    int n, nxt;
    if (rst == 1'b0) begin
      modelReset();
      return;
    end
    hist.push_back(stim);
    void'(hist.pop_front());
    n = hist.size();

    poff = mDeb[1]; thr = mDeb[2]; clu = mDeb[3]; brk = mDeb[4];
    rise = mDeb[0] && !mPonPrev;
    nxt = mState;
    if (mState == S_OFF) begin
      if (rise && !poff) nxt = S_NS;
    end else if (poff) nxt = S_OFF;
    else if (mState == S_NS) begin
      if (thr && !clu) nxt = S_OFF;
      else if (thr && clu && !brk) nxt = S_ST;
    end else if (mState == S_ST) begin
      if (brk) nxt = S_NS;
      else if (thr && !clu) nxt = S_MV;
    end else begin
      if (brk) nxt = S_NS;
      else if (clu || !thr) nxt = S_ST;
      else if (mDeb[5] != mRev) nxt = S_OFF;
    end
    enterOff = (nxt == S_OFF) && (mState != S_OFF);

    nRev = mRev;
    if (enterOff) nRev = 0;
    else if ((mState == S_ST || mState == S_MV) && clu) nRev = mDeb[5];

    if (nxt == S_OFF) nCmd = 8'h80;
    else nCmd = {2'b10, mDeb[9], mDeb[8], mDeb[7], mDeb[6],
                 (nxt == S_MV) && nRev, (nxt == S_MV) && !nRev};
    mValid   = (mCmd != mCmdPrev);
    mCmdPrev = mCmd;
    mCmd     = nCmd;

    if (mState == S_MV) begin
      mRun++;
      if ((mRun % MT) == 0 && mMile < MAXMIL) mMile++;
    end else mRun = 0;
    if (enterOff) mMile = 0;

    if ((mDeb[6] || mDeb[7]) && mState != S_OFF) begin
      mBlinkRun++;
      phaseOn = (((mBlinkRun - 1) / BH) % 2) == 0;
      mLl = mDeb[6] && phaseOn;
      mLr = mDeb[7] && phaseOn;
    end else begin
      mBlinkRun = 0; mLl = 0; mLr = 0;
    end

    for (int b = 0; b < 10; b++) begin
      v = hist[n-3][b];
      same = 1;
      for (int j = 4; j <= D + 2; j++) if (hist[n-j][b] != v) same = 0;
      newDeb[b] = same ? v : mDeb[b];
    end
    mPonPrev = mDeb[0];
    mDeb     = newDeb;
    mState   = nxt;
    mRev     = nRev;
  endtask

  task automatic compareAll();
    checkOutput("state", bus.state, mState);
    checkOutput("cmd", bus.cmd, mCmd);
    checkOutput("cmd_valid", bus.cmd_valid, mValid);
    checkOutput("reversing", bus.reversing, mRev);
    checkOutput("mileage", bus.mileage, mMile);
    checkOutput("left_led", bus.left_led, mLl);
    checkOutput("right_led", bus.right_led, mLr);
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    compareAll();
  endtask

  task automatic applyStimulus(input bit [9:0] v, input int cycles);
    stim = v;
    bus.power_on_btn    = v[0];
    bus.power_off_btn   = v[1];
    bus.throttle        = v[2];
    bus.clutch          = v[3];
    bus.brake           = v[4];
    bus.reverse_sw      = v[5];
    bus.turn_left       = v[6];
    bus.turn_right      = v[7];
    bus.place_barrier   = v[8];
    bus.destroy_barrier = v[9];
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic powerUp();
    applyStimulus(PON, 8);
    applyStimulus('0, 8);
  endtask

  function automatic bit pick(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  initial begin
    bit [9:0] r;
    modelReset();
    rst = 1'b0;
    applyStimulus('0, 3);
    checkOutput("rst_state", bus.state, 0);
    checkOutput("rst_cmd", bus.cmd, 8'h80);
    checkOutput("rst_valid", bus.cmd_valid, 0);
    checkOutput("rst_mileage", bus.mileage, 0);
    rst = 1'b1;
    applyStimulus('0, 4);

    // power on: state moves exactly 2+D+1 cycles after the press
    applyStimulus(PON, 6);
    checkOutput("pon_early", bus.state, S_OFF);
    applyStimulus(PON, 1);
    checkOutput("pon_state", bus.state, S_NS);
    applyStimulus(PON, 1);
    applyStimulus('0, 8);
    checkOutput("pon_cmd", bus.cmd, 8'h80);

    // start and drive forward, accumulate mileage
    applyStimulus(THR | CLU, 7);
    checkOutput("starting", bus.state, S_ST);
    applyStimulus(THR, 7);
    checkOutput("moving", bus.state, S_MV);
    checkOutput("fwd_cmd", bus.cmd, 8'h81);
    applyStimulus(THR, 1);
    checkOutput("fwd_valid", bus.cmd_valid, 1);
    applyStimulus(THR, 29);
    checkOutput("mileage3", bus.mileage, 3);

    // saturation, then power off clears mileage
    applyStimulus(THR, 150);
    checkOutput("mileage_sat", bus.mileage, MAXMIL);
    applyStimulus(THR | POFF, 7);
    checkOutput("poff_state", bus.state, S_OFF);
    checkOutput("poff_mileage", bus.mileage, 0);
    checkOutput("poff_cmd", bus.cmd, 8'h80);
    applyStimulus('0, 10);

    // reverse gear then gear crash
    powerUp();
    applyStimulus(THR | CLU | REV, 10);
    checkOutput("rev_latch", bus.reversing, 1);
    applyStimulus(THR | REV, 8);
    checkOutput("rev_moving", bus.state, S_MV);
    checkOutput("rev_cmd", bus.cmd, 8'h82);
    applyStimulus(THR, 8);
    checkOutput("crash_state", bus.state, S_OFF);
    checkOutput("crash_rev", bus.reversing, 0);

    // stall, then a short brake glitch while moving
    applyStimulus('0, 8);
    powerUp();
    applyStimulus(THR, 7);
    checkOutput("stall", bus.state, S_OFF);
    applyStimulus('0, 8);
    powerUp();
    applyStimulus(THR | CLU, 10);
    applyStimulus(THR, 10);
    applyStimulus(THR | BRK, 2);
    applyStimulus(THR, 10);
    checkOutput("glitch", bus.state, S_MV);

    // hazard lights
    applyStimulus(POFF, 8);
    applyStimulus('0, 8);
    powerUp();
    applyStimulus(TURNS, 6);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(TURNS, 1);
      checkOutput("hazard_l", bus.left_led, (i % 6) < 3);
      checkOutput("hazard_r", bus.right_led, (i % 6) < 3);
    end
    checkOutput("turn_bits", bus.cmd[3:2], 2'b11);
    applyStimulus(TURNS | POFF, 8);
    checkOutput("off_leds", {bus.left_led, bus.right_led}, 2'b00);
    applyStimulus('0, 8);

    // randomized switch activity with occasional mid-run resets
    for (int s = 0; s < 400; s++) begin
      r = {pick(30), pick(30), pick(40), pick(40), pick(30), pick(15),
           pick(40), pick(70), pick(4), pick(30)};
      if ($urandom_range(99) < 2) begin
        rst = 1'b0;
        applyStimulus(r, $urandom_range(1, 2));
        rst = 1'b1;
      end else if ($urandom_range(99) < 15) begin
        applyStimulus(r, $urandom_range(15, 40));
      end else begin
        applyStimulus(r, $urandom_range(1, 10));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
